// File: rtl/bigmul_job_arbiter_pkg.sv
// Shared types and widths for the bigmul job arbiter.
package bigmul_job_arbiter_pkg;

    localparam int unsigned CyclesW = 64;
    localparam int unsigned JobsW   = 32;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLaunch = 3'd1,
        StWait   = 3'd2,
        StResp   = 3'd3,
        StDrain  = 3'd4
    } state_e;

endpackage

// File: rtl/bigmul_job_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, cyclically.
module bigmul_job_arbiter_rr_arbiter #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = 2
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   rr_ptr_i,
    output logic              any_o,
    output logic [IdxW-1:0]   winner_o,
    output logic [NumReq-1:0] onehot_o
);

    logic [2*NumReq-1:0] doubled;
    logic [NumReq-1:0]   rotated;
    logic [IdxW:0]       sum;

    // Bit k of rotated is request (rr_ptr + k) mod NumReq.
    assign doubled = {req_i, req_i} >> rr_ptr_i;
    assign rotated = doubled[NumReq-1:0];

    always_comb begin
        any_o    = 1'b0;
        winner_o = '0;
        onehot_o = '0;
        sum      = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (!any_o && rotated[k]) begin
                any_o = 1'b1;
                sum   = {1'b0, rr_ptr_i} + (IdxW+1)'(k);
                if (sum >= (IdxW+1)'(NumReq)) begin
                    sum = sum - (IdxW+1)'(NumReq);
                end
                winner_o = sum[IdxW-1:0];
            end
        end
        if (any_o) begin
            onehot_o = NumReq'(1) << winner_o;
        end
    end

endmodule

// File: rtl/bigmul_job_arbiter.sv
// Shares one bigmul unit between NUM_REQ requesters: round-robin grant, start pulse,
// wait for done with a watchdog, one-cycle response, and drain after a timeout.
module bigmul_job_arbiter
    import bigmul_job_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned IDX_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 300000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic                 rsp_err,
    output logic [CyclesW-1:0]   rsp_cycles,
    output logic                 mul_start,
    input  logic                 mul_busy,
    input  logic                 mul_done,
    input  logic [CyclesW-1:0]   mul_cycles,
    output logic [JobsW-1:0]     jobs_total,
    output logic                 err_sticky
);

    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     winner_q, winner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [WdW-1:0]       wd_q, wd_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [CyclesW-1:0]   rsp_cycles_q, rsp_cycles_d;
    logic [JobsW-1:0]     jobs_q, jobs_d;
    logic                 err_sticky_q, err_sticky_d;

    logic                 arb_any;
    logic [IDX_W-1:0]     arb_winner;
    logic [NUM_REQ-1:0]   arb_onehot;

    bigmul_job_arbiter_rr_arbiter #(
        .NumReq (NUM_REQ),
        .IdxW   (IDX_W)
    ) u_rr_arbiter (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .any_o    (arb_any),
        .winner_o (arb_winner),
        .onehot_o (arb_onehot)
    );

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        wd_d         = wd_q;
        rsp_err_d    = rsp_err_q;
        rsp_cycles_d = rsp_cycles_q;
        jobs_d       = jobs_q;
        err_sticky_d = err_sticky_q;
        mul_start    = 1'b0;
        rsp_valid    = '0;

        unique case (state_q)
            StIdle: begin
                // A busy unit here means a job survived a reset; never double-start it.
                if (arb_any && !mul_busy) begin
                    winner_d = arb_winner;
                    grant_d  = arb_onehot;
                    state_d  = StLaunch;
                end
            end
            StLaunch: begin
                mul_start = 1'b1;
                wd_d      = '0;
                state_d   = StWait;
            end
            StWait: begin
                wd_d = wd_q + 1'b1;
                if (mul_done) begin
                    rsp_cycles_d = mul_cycles;
                    rsp_err_d    = 1'b0;
                    state_d      = StResp;
                end else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_cycles_d = '0;
                    rsp_err_d    = 1'b1;
                    err_sticky_d = 1'b1;
                    state_d      = StResp;
                end
            end
            StResp: begin
                rsp_valid = grant_q;
                grant_d   = '0;
                rr_ptr_d  = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
                if (!rsp_err_q) begin
                    jobs_d = jobs_q + 1'b1;
                end
                state_d = rsp_err_q ? StDrain : StIdle;
            end
            StDrain: begin
                // The timed-out job cannot be aborted; its late done is simply dropped.
                if (!mul_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            winner_q     <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            wd_q         <= '0;
            rsp_err_q    <= 1'b0;
            rsp_cycles_q <= '0;
            jobs_q       <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            wd_q         <= wd_d;
            rsp_err_q    <= rsp_err_d;
            rsp_cycles_q <= rsp_cycles_d;
            jobs_q       <= jobs_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign grant      = grant_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_cycles = rsp_cycles_q;
    assign jobs_total = jobs_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_bigmul_job_arbiter.sv
// Directed bench for bigmul_job_arbiter driving a behavioural multiplier with programmable latency.
module tb_bigmul_job_arbiter;

    localparam int unsigned NumReq  = 4;
    localparam int unsigned Timeout = 32;
    localparam logic [63:0] CycBase = 64'hC0DE_0000_0000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NumReq-1:0] req = '0;
    logic [NumReq-1:0] grant;
    logic [NumReq-1:0] rsp_valid;
    logic              rsp_err;
    logic [63:0]       rsp_cycles;
    logic              mul_start;
    logic              mul_busy;
    logic              mul_done;
    logic [63:0]       mul_cycles;
    logic [31:0]       jobs_total;
    logic              err_sticky;

    always #5 clk = ~clk;

    bigmul_job_arbiter #(
        .NUM_REQ        (NumReq),
        .IDX_W          (2),
        .TIMEOUT_CYCLES (Timeout)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant      (grant),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_cycles (rsp_cycles),
        .mul_start  (mul_start),
        .mul_busy   (mul_busy),
        .mul_done   (mul_done),
        .mul_cycles (mul_cycles),
        .jobs_total (jobs_total),
        .err_sticky (err_sticky)
    );

    // Unit model: busy for lat cycles after a start, done in the last busy cycle.
    // It has no reset so a job keeps running across a DUT reset.
    logic        m_busy = 1'b0;
    int unsigned m_cnt  = 0;
    logic [63:0] m_cyc  = '0;
    int unsigned lat    = 1;

    always @(posedge clk) begin
        if (mul_start && !m_busy) begin
            m_busy <= 1'b1;
            m_cnt  <= lat;
            m_cyc  <= CycBase + 64'(lat) * 64'h1_0001;
        end else if (m_busy) begin
            if (m_cnt == 1) m_busy <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end
    end

    assign mul_busy   = m_busy;
    assign mul_done   = m_busy && (m_cnt == 1);
    assign mul_cycles = mul_done ? m_cyc : 64'h0;

    int unsigned checks     = 0;
    int unsigned failures   = 0;
    int unsigned bad_starts = 0;
    int unsigned exp_jobs   = 0;
    logic        exp_sticky = 1'b0;

    always @(negedge clk) begin
        if (mul_start && (mul_busy || grant == '0)) bad_starts++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  req_mid;
        logic [3:0]  req_after;
        int unsigned lat;
        int unsigned idx;
        logic        err;
        int unsigned start_dly;
    } vec_t;

    vec_t vecs[14];

    // Entered at a negedge; returns at the negedge just after the response cycle.
    task automatic run_vec(input vec_t v);
        int unsigned n;
        logic [63:0] exp_cyc;
        req = v.req;
        lat = v.lat;
        n = 0;
        do begin @(negedge clk); n++; end while (!mul_start && n < 300);
        check("start_delay", 64'(n), 64'(v.start_dly));
        check("grant", 64'(grant), 64'(1) << v.idx);
        req = v.req_mid;
        n = 0;
        do begin @(negedge clk); n++; end while (rsp_valid == '0 && n < 400);
        check("rsp_delay", 64'(n), v.err ? 64'(Timeout + 1) : 64'(v.lat + 1));
        check("rsp_valid", 64'(rsp_valid), 64'(1) << v.idx);
        check("rsp_err", 64'(rsp_err), 64'(v.err));
        exp_cyc = v.err ? 64'h0 : CycBase + 64'(v.lat) * 64'h1_0001;
        check("rsp_cycles", rsp_cycles, exp_cyc);
        if (v.err) exp_sticky = 1'b1;
        else       exp_jobs++;
        req = v.req_after;
        @(negedge clk);
        check("jobs_total", 64'(jobs_total), 64'(exp_jobs));
        check("err_sticky", 64'(err_sticky), 64'(exp_sticky));
        check("grant_released", 64'(grant), 64'h0);
        check("rsp_valid_pulse", 64'(rsp_valid), 64'h0);
    endtask

    initial begin
        int unsigned n;
        // req, req_mid, req_after, lat, winner, err, start delay
        vecs[0]  = '{4'b1111, 4'b1111, 4'b1111,   5, 0, 1'b0,  1};
        vecs[1]  = '{4'b1111, 4'b1111, 4'b1111,   6, 1, 1'b0,  1};
        vecs[2]  = '{4'b1111, 4'b1111, 4'b1111,   7, 2, 1'b0,  1};
        vecs[3]  = '{4'b1111, 4'b1111, 4'b1111,   8, 3, 1'b0,  1};
        vecs[4]  = '{4'b1111, 4'b1111, 4'b0000,   9, 0, 1'b0,  1};
        vecs[5]  = '{4'b0010, 4'b0010, 4'b0000,  10, 1, 1'b0,  1};
        vecs[6]  = '{4'b0001, 4'b0001, 4'b0000,  11, 0, 1'b0,  1};
        vecs[7]  = '{4'b1001, 4'b1001, 4'b0000,   4, 3, 1'b0,  1};
        vecs[8]  = '{4'b1100, 4'b1100, 4'b0000,   3, 2, 1'b0,  1};
        vecs[9]  = '{4'b0001, 4'b1001, 4'b1001,   6, 0, 1'b0,  1};
        vecs[10] = '{4'b1001, 4'b1001, 4'b0000,   5, 3, 1'b0,  1};
        vecs[11] = '{4'b0100, 4'b0100, 4'b0100, 100, 2, 1'b1,  1};
        vecs[12] = '{4'b0100, 4'b0100, 4'b0000,  12, 2, 1'b0, 69};
        vecs[13] = '{4'b0001, 4'b0001, 4'b0000,  32, 0, 1'b0,  1};

        repeat (3) @(negedge clk);
        check("reset_grant", 64'(grant), 64'h0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        check("reset_mul_start", 64'(mul_start), 64'h0);
        check("reset_jobs", 64'(jobs_total), 64'h0);
        check("reset_sticky", 64'(err_sticky), 64'h0);
        check("reset_rsp_cycles", rsp_cycles, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // Reset while the unit is mid-job; the next start must wait for busy to drop.
        req = 4'b0010;
        lat = 40;
        n = 0;
        do begin @(negedge clk); n++; end while (!mul_start && n < 300);
        check("pre_reset_grant", 64'(grant), 64'h2);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_grant", 64'(grant), 64'h0);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("midrst_rsp_err", 64'(rsp_err), 64'h0);
        check("midrst_rsp_cycles", rsp_cycles, 64'h0);
        check("midrst_jobs", 64'(jobs_total), 64'h0);
        check("midrst_sticky", 64'(err_sticky), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_jobs   = 0;
        exp_sticky = 1'b0;
        run_vec('{4'b0010, 4'b0010, 4'b0000, 4, 1, 1'b0, 35});

        check("no_start_while_busy", 64'(bad_starts), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
